// File: rtl/player_ground_collider.sv
// player_ground_collider
//   Scans a platform table once per request and returns the highest platform
//   surface (smallest y) at or below the player's feet. The result feeds the
//   player position controller's ground inputs.
//
// Ports
//   clk_player_control          system clock
//   reset_n                     synchronous active-low reset
//   start                       1-cycle scan request, ignored while busy
//   player_pos_x/_y             player top-left corner, pixels
//   plat_addr                   platform table read address
//   plat_valid/_x0/_x1/_y       table read data, one cycle after plat_addr
//   busy                        scan in progress
//   scan_done                   1-cycle pulse, new results valid
//   collider_ground_h_player    selected surface y, 0 when none qualifies
//   is_collider_ground_player   a platform qualified in the last scan
module player_ground_collider #(
  parameter int unsigned NUM_PLATFORMS = 8,
  parameter int unsigned PLAYER_W      = 30,
  parameter int unsigned PLAYER_H      = 30,
  parameter int unsigned SNAP_TOL      = 2,
  localparam int unsigned AddrW = (NUM_PLATFORMS > 1) ? $clog2(NUM_PLATFORMS) : 1
) (
  input  logic             clk_player_control,
  input  logic             reset_n,
  input  logic             start,
  input  logic [9:0]       player_pos_x,
  input  logic [9:0]       player_pos_y,
  output logic [AddrW-1:0] plat_addr,
  input  logic             plat_valid,
  input  logic [9:0]       plat_x0,
  input  logic [9:0]       plat_x1,
  input  logic [9:0]       plat_y,
  output logic             busy,
  output logic             scan_done,
  output logic [9:0]       collider_ground_h_player,
  output logic             is_collider_ground_player
);

  localparam logic [10:0]      PlayerW  = 11'(PLAYER_W);
  localparam logic [10:0]      PlayerH  = 11'(PLAYER_H);
  localparam logic [10:0]      SnapTol  = 11'(SNAP_TOL);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(NUM_PLATFORMS - 1);

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [9:0]       px_q, px_d, py_q, py_d;
  logic             dv_q, dv_d;
  logic [9:0]       best_h_q, best_h_d;
  logic             best_found_q, best_found_d;
  logic [9:0]       h_q, h_d;
  logic             is_q, is_d;
  logic             done_q, done_d;

  logic        qualify, take;
  logic [9:0]  merged_h;
  logic        merged_found;

  // Evaluate the entry currently on the read bus against the snapshot position.
  // All compares are 11-bit so the +W/+H/+TOL sums cannot wrap.
  always_comb begin
    qualify = dv_q && plat_valid
           && ({1'b0, px_q} < {1'b0, plat_x1})
           && (({1'b0, px_q} + PlayerW) > {1'b0, plat_x0})
           && (({1'b0, plat_y} + SnapTol) >= ({1'b0, py_q} + PlayerH));
    // Strict less-than keeps the lower index on ties.
    take         = qualify && (!best_found_q || (plat_y < best_h_q));
    merged_h     = take ? plat_y : best_h_q;
    merged_found = best_found_q | take;
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    px_d         = px_q;
    py_d         = py_q;
    best_h_d     = best_h_q;
    best_found_d = best_found_q;
    h_d          = h_q;
    is_d         = is_q;
    done_d       = 1'b0;
    // Data on the bus belongs to an address issued in the previous SCAN cycle.
    dv_d         = (state_q == StScan);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          px_d         = player_pos_x;
          py_d         = player_pos_y;
          addr_d       = '0;
          best_h_d     = '0;
          best_found_d = 1'b0;
          state_d      = StScan;
        end
      end
      StScan: begin
        best_h_d     = merged_h;
        best_found_d = merged_found;
        if (addr_q == LastAddr) begin
          state_d = StCommit;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StCommit: begin
        // The last entry's data is on the bus now; fold it straight into the result.
        h_d     = merged_h;
        is_d    = merged_found;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_player_control) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      px_q         <= '0;
      py_q         <= '0;
      dv_q         <= 1'b0;
      best_h_q     <= '0;
      best_found_q <= 1'b0;
      h_q          <= '0;
      is_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      px_q         <= px_d;
      py_q         <= py_d;
      dv_q         <= dv_d;
      best_h_q     <= best_h_d;
      best_found_q <= best_found_d;
      h_q          <= h_d;
      is_q         <= is_d;
      done_q       <= done_d;
    end
  end

  assign plat_addr                 = addr_q;
  assign busy                      = (state_q != StIdle);
  assign scan_done                 = done_q;
  assign collider_ground_h_player  = h_q;
  assign is_collider_ground_player = is_q;

endmodule

// File: tb/tb_player_ground_collider.sv
// Bench for player_ground_collider: directed cases plus randomized tables
// checked against a loop-based reference model.
module tb_player_ground_collider;

  localparam int NP = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [9:0] player_pos_x, player_pos_y;
  logic [2:0] plat_addr;
  logic       plat_valid;
  logic [9:0] plat_x0, plat_x1, plat_y;
  logic       busy, scan_done;
  logic [9:0] collider_ground_h_player;
  logic       is_collider_ground_player;

  int n_checks = 0;
  int n_fail   = 0;

  logic       m_valid [NP];
  logic [9:0] m_x0    [NP];
  logic [9:0] m_x1    [NP];
  logic [9:0] m_y     [NP];

  always #5 clk = ~clk;

  player_ground_collider dut (
    .clk_player_control        (clk),
    .reset_n                   (reset_n),
    .start                     (start),
    .player_pos_x              (player_pos_x),
    .player_pos_y              (player_pos_y),
    .plat_addr                 (plat_addr),
    .plat_valid                (plat_valid),
    .plat_x0                   (plat_x0),
    .plat_x1                   (plat_x1),
    .plat_y                    (plat_y),
    .busy                      (busy),
    .scan_done                 (scan_done),
    .collider_ground_h_player  (collider_ground_h_player),
    .is_collider_ground_player (is_collider_ground_player)
  );

  // Platform table with one cycle of read latency.
  always @(posedge clk) begin
    plat_valid <= m_valid[plat_addr];
    plat_x0    <= m_x0[plat_addr];
    plat_x1    <= m_x1[plat_addr];
    plat_y     <= m_y[plat_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: {found, h} for the current table and a player position.
  function automatic logic [10:0] model(input int px, input int py);
    bit found = 0;
    int best  = 0;
    for (int k = 0; k < NP; k++) begin
      if (m_valid[k] && px < int'(m_x1[k]) && px + 30 > int'(m_x0[k]) &&
          int'(m_y[k]) + 2 >= py + 30 && (!found || int'(m_y[k]) < best)) begin
        found = 1;
        best  = int'(m_y[k]);
      end
    end
    return {found, 10'(best)};
  endfunction

  function automatic logic [9:0] clamp10(input int v);
    if (v < 0) return 10'd0;
    if (v > 1023) return 10'd1023;
    return 10'(v);
  endfunction

  task automatic clear_table();
    for (int k = 0; k < NP; k++) begin
      m_valid[k] = 1'b0;
      m_x0[k]    = '0;
      m_x1[k]    = '0;
      m_y[k]     = '0;
    end
  endtask

  task automatic set_entry(input int k, input int x0, input int x1, input int y);
    m_valid[k] = 1'b1;
    m_x0[k]    = 10'(x0);
    m_x1[k]    = 10'(x1);
    m_y[k]     = 10'(y);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one scan and check latency, busy, result and result hold.
  task automatic run_scan(input string tag, input int px, input int py, input bit scramble);
    int          cyc;
    bit          seen;
    bit          busy_ok;
    logic [10:0] exp;
    exp          = model(px, py);
    player_pos_x = 10'(px);
    player_pos_y = 10'(py);
    start        = 1'b1;
    tick();
    start   = 1'b0;
    cyc     = 1;
    seen    = 0;
    busy_ok = 1;
    while (!seen && cyc < 40) begin
      if (scramble) begin
        player_pos_x = 10'($urandom);
        player_pos_y = 10'($urandom);
      end
      if (scan_done) begin
        seen = 1;
      end else begin
        if (!busy) busy_ok = 0;
        tick();
        cyc++;
      end
    end
    check_eq({tag, " latency"}, cyc, 10);
    check_eq({tag, " busy during scan"}, 32'(busy_ok), 1);
    check_eq({tag, " busy at done"}, 32'(busy), 0);
    check_eq({tag, " is"}, 32'(is_collider_ground_player), 32'(exp[10]));
    check_eq({tag, " h"}, 32'(collider_ground_h_player), 32'(exp[9:0]));
    tick();
    check_eq({tag, " done pulse"}, 32'(scan_done), 0);
    check_eq({tag, " h hold"}, 32'(collider_ground_h_player), 32'(exp[9:0]));
  endtask

  initial begin
    int first;
    int pulses;
    int px, py;

    // Reset with start held: nothing may start.
    clear_table();
    reset_n      = 1'b0;
    start        = 1'b1;
    player_pos_x = 10'd320;
    player_pos_y = 10'd240;
    tick();
    tick();
    check_eq("reset busy", 32'(busy), 0);
    check_eq("reset done", 32'(scan_done), 0);
    check_eq("reset h", 32'(collider_ground_h_player), 0);
    check_eq("reset is", 32'(is_collider_ground_player), 0);
    check_eq("reset addr", 32'(plat_addr), 0);
    start   = 1'b0;
    reset_n = 1'b1;
    tick();
    tick();
    check_eq("post reset busy", 32'(busy), 0);

    // Single entry.
    set_entry(0, 300, 400, 300);
    run_scan("single", 320, 240, 0);

    // Highest qualifying surface wins; y=260 lies above the feet.
    set_entry(1, 310, 360, 280);
    set_entry(2, 300, 400, 260);
    run_scan("highest", 320, 240, 0);

    // Horizontal edge touch vs. one-pixel overlap.
    clear_table();
    set_entry(0, 300, 400, 300);
    run_scan("edge touch", 270, 240, 0);
    run_scan("edge overlap", 271, 240, 0);
    run_scan("right edge", 400, 240, 0);
    run_scan("right inside", 399, 240, 0);

    // Snap tolerance: feet 2 px into the surface still stands.
    run_scan("standing", 320, 272, 0);
    run_scan("sunk too far", 320, 273, 0);

    // Snapshot: inputs scrambled mid-scan.
    run_scan("snapshot", 320, 240, 1);

    // Tie on y: result is the shared y either way.
    set_entry(3, 250, 350, 300);
    set_entry(5, 320, 330, 290);
    set_entry(6, 0, 1023, 290);
    run_scan("tie", 320, 240, 0);

    // Second start while busy is ignored.
    clear_table();
    set_entry(0, 300, 400, 300);
    player_pos_x = 10'd320;
    player_pos_y = 10'd240;
    start        = 1'b1;
    tick();
    first  = 0;
    pulses = 0;
    for (int c = 1; c <= 25; c++) begin
      start = (c == 3);
      if (scan_done) begin
        pulses++;
        if (first == 0) first = c;
      end
      tick();
    end
    start = 1'b0;
    check_eq("restart first done", first, 10);
    check_eq("restart pulse count", pulses, 1);
    check_eq("restart h", 32'(collider_ground_h_player), 300);

    // Reset mid-scan aborts with no done and clears outputs.
    start = 1'b1;
    tick();
    start  = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 25; c++) begin
      reset_n = (c != 5);
      if (scan_done) pulses++;
      tick();
    end
    reset_n = 1'b1;
    check_eq("abort pulses", pulses, 0);
    check_eq("abort busy", 32'(busy), 0);
    check_eq("abort h", 32'(collider_ground_h_player), 0);
    check_eq("abort is", 32'(is_collider_ground_player), 0);

    // Randomized tables around the player.
    for (int it = 0; it < 30; it++) begin
      px = int'($urandom_range(0, 950));
      py = int'($urandom_range(0, 900));
      for (int k = 0; k < NP; k++) begin
        m_valid[k] = ($urandom_range(0, 4) != 0);
        m_x0[k]    = clamp10(px + int'($urandom_range(0, 200)) - 100);
        m_x1[k]    = clamp10(int'(m_x0[k]) + int'($urandom_range(0, 120)));
        m_y[k]     = clamp10(py + 28 + int'($urandom_range(0, 60)) - 20);
        if (k > 0 && $urandom_range(0, 3) == 0) m_y[k] = m_y[k-1];
      end
      run_scan($sformatf("rand%0d", it), px, py, it[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
